uart_rx_param: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8N1 receiver. Data width, parity mode and stop-bit count are configurable. Each bit is decided by a 3-sample majority vote, false start bits are rejected, and parity, framing and overrun errors are reported. The receiver never stalls on the consumer: a one-deep output register with valid/ready handshake decouples it, so back-to-back frames are accepted while earlier data waits.

---
 rtl/uart_rx_param.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority per bit, false-start rejection,
// parity/framing/overrun reporting and a one-deep valid/ready output register.
module uart_rx_param #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_50m,
    input  logic                 start,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_valid,
    input  logic                 rx_data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int         CYCLE    = CLK_FRE * 1000000 / BAUD_RATE;
    localparam logic [15:0] CNT_S0   = 16'(CYCLE / 2 - 2);
    localparam logic [15:0] CNT_S1   = 16'(CYCLE / 2 - 1);
    localparam logic [15:0] CNT_MID  = 16'(CYCLE / 2);
    localparam logic [15:0] CNT_END  = 16'(CYCLE - 1);
    localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state;
    logic [15:0]          cycle_cnt;
    logic [3:0]           bit_cnt;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] data_sh;
    logic                 perr;
    logic                 ferr;
    logic                 s0;
    logic                 s1;

    logic rs_meta;
    logic rs;
    logic rs_d;

    // Synchroniser resets to the idle level so releasing reset never looks like a start edge.
    always_ff @(posedge clk_50m or negedge start) begin
        if (!start) begin
            rs_meta <= 1'b1;
            rs      <= 1'b1;
            rs_d    <= 1'b1;
        end else begin
            rs_meta <= rx_pin;
            rs      <= rs_meta;
            rs_d    <= rs;
        end
    end

    logic fall;
    logic maj;
    logic at_mid;
    logic at_end;
    logic exp_par;

    assign fall    = rs_d & ~rs;
    assign maj     = (s0 & s1) | (s0 & rs) | (s1 & rs);
    assign at_mid  = (cycle_cnt == CNT_MID);
    assign at_end  = (cycle_cnt == CNT_END);
    assign exp_par = (PARITY == 1) ? ~(^data_sh) : (^data_sh);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk_50m or negedge start) begin
        if (!start) begin
            state         <= IDLE;
            cycle_cnt     <= '0;
            bit_cnt       <= '0;
            stop_idx      <= 1'b0;
            data_sh       <= '0;
            perr          <= 1'b0;
            ferr          <= 1'b0;
            s0            <= 1'b1;
            s1            <= 1'b1;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
                overrun       <= 1'b0;
            end
            if (cycle_cnt == CNT_S0) s0 <= rs;
            if (cycle_cnt == CNT_S1) s1 <= rs;
            cycle_cnt <= cycle_cnt + 16'd1;

            case (state)
                IDLE: begin
                    cycle_cnt <= '0;
                    if (fall) begin
                        state    <= START;
                        bit_cnt  <= '0;
                        stop_idx <= 1'b0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                    end
                end
                START: begin
                    if (at_mid && maj) begin
                        state     <= IDLE;
                        cycle_cnt <= '0;
                    end else if (at_end) begin
                        state     <= DATA;
                        cycle_cnt <= '0;
                    end
                end
                DATA: begin
                    // LSB arrives first, so shifting right leaves it at bit 0.
                    if (at_mid) data_sh <= {maj, data_sh[DATA_BITS-1:1]};
                    if (at_end) begin
                        cycle_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                PAR: begin
                    if (at_mid && (maj != exp_par)) perr <= 1'b1;
                    if (at_end) begin
                        state     <= STOP;
                        cycle_cnt <= '0;
                    end
                end
                STOP: begin
                    if (at_mid) begin
                        if (STOP_BITS == 2 && !stop_idx) begin
                            if (!maj) ferr <= 1'b1;
                        end else begin
                            // Finish at the last stop mid-point so the next start edge is not missed.
                            state     <= IDLE;
                            cycle_cnt <= '0;
                            if (!rx_data_valid || rx_data_ready) begin
                                rx_data       <= data_sh;
                                parity_err    <= perr;
                                frame_err     <= ferr | ~maj;
                                rx_data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end else if (at_end) begin
                        stop_idx  <= 1'b1;
                        cycle_cnt <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cycle_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, 7E1 and 8N2 instances at 16 clocks per bit.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       start = 1'b0;
    logic [2:0] rx_line = 3'b111;
    logic [2:0] ready = 3'b000;

    logic [7:0] d0, d2;
    logic [6:0] d1;
    logic [2:0] vld, perr, ferr, ovr, bsy;

    int checks = 0;
    int errors = 0;
    int vcnt0 = 0;
    logic [7:0] cap0 = '0;
    logic       cap_perr0 = 1'b0;
    logic       cap_ferr0 = 1'b0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FRE(16), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk_50m(clk), .start(start), .rx_pin(rx_line[0]), .rx_data(d0), .rx_data_valid(vld[0]),
        .rx_data_ready(ready[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(bsy[0]));

    uart_rx_param #(.CLK_FRE(16), .BAUD_RATE(1000000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk_50m(clk), .start(start), .rx_pin(rx_line[1]), .rx_data(d1), .rx_data_valid(vld[1]),
        .rx_data_ready(ready[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(bsy[1]));

    uart_rx_param #(.CLK_FRE(16), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk_50m(clk), .start(start), .rx_pin(rx_line[2]), .rx_data(d2), .rx_data_valid(vld[2]),
        .rx_data_ready(ready[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .busy(bsy[2]));

    always @(negedge clk) begin
        if (vld[0]) begin
            vcnt0     <= vcnt0 + 1;
            cap0      <= d0;
            cap_perr0 <= perr[0];
            cap_ferr0 <= ferr[0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives n bits LSB first, each held for one 16-clock bit period.
    task automatic send(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_line[sel] = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic accept(input int sel);
        ready[sel] = 1'b1;
        @(negedge clk);
        ready[sel] = 1'b0;
    endtask

    initial begin
        int v;
        repeat (3) @(negedge clk);
        chk("rst_valid", {29'b0, vld}, 0);
        chk("rst_data0", {24'b0, d0}, 0);
        chk("rst_busy", {29'b0, bsy}, 0);
        chk("rst_ovr", {29'b0, ovr}, 0);
        start = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1, ready high: one-clock valid pulse carrying 0xA5
        ready[0] = 1'b1;
        v = vcnt0;
        send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        repeat (4) @(negedge clk);
        chk("a5_pulses", vcnt0 - v, 1);
        chk("a5_data", {24'b0, cap0}, 32'hA5);
        chk("a5_perr", {31'b0, cap_perr0}, 0);
        chk("a5_ferr", {31'b0, cap_ferr0}, 0);
        chk("a5_valid_cleared", {31'b0, vld[0]}, 0);
        ready[0] = 1'b0;

        // 4-clock glitch on idle line is rejected
        v = vcnt0;
        rx_line[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_no_valid", vcnt0 - v, 0);
        chk("glitch_idle", {31'b0, bsy[0]}, 0);

        // 1-clock spike at mid of data bit 3 of 0xFF
        send(0, 16'h0000, 1);
        send(0, 16'hFFFF, 3);
        rx_line[0] = 1'b1;
        repeat (8) @(negedge clk);
        rx_line[0] = 1'b0;
        @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (7) @(negedge clk);
        send(0, 16'hFFFF, 5);
        chk("spike_valid", {31'b0, vld[0]}, 1);
        chk("spike_data", {24'b0, d0}, 32'hFF);
        chk("spike_ferr", {31'b0, ferr[0]}, 0);
        accept(0);
        chk("spike_accepted", {31'b0, vld[0]}, 0);

        // 7E1
        send(1, {6'b0, 1'b1, 1'b0, 7'h35, 1'b0}, 10);
        chk("e_good_valid", {31'b0, vld[1]}, 1);
        chk("e_good_data", {25'b0, d1}, 32'h35);
        chk("e_good_perr", {31'b0, perr[1]}, 0);
        accept(1);
        send(1, {6'b0, 1'b1, 1'b1, 7'h35, 1'b0}, 10);
        chk("e_bad_valid", {31'b0, vld[1]}, 1);
        chk("e_bad_data", {25'b0, d1}, 32'h35);
        chk("e_bad_perr", {31'b0, perr[1]}, 1);
        chk("e_bad_ferr", {31'b0, ferr[1]}, 0);
        accept(1);

        // 8N2: good frame, then second stop bit low
        send(2, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        chk("s2_good_data", {24'b0, d2}, 32'h3C);
        chk("s2_good_ferr", {31'b0, ferr[2]}, 0);
        accept(2);
        send(2, {5'b0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
        rx_line[2] = 1'b1;
        chk("s2_bad_valid", {31'b0, vld[2]}, 1);
        chk("s2_bad_data", {24'b0, d2}, 32'h3C);
        chk("s2_bad_ferr", {31'b0, ferr[2]}, 1);
        accept(2);

        // Overrun with ready low
        send(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
        send(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
        chk("ovr_data", {24'b0, d0}, 32'h11);
        chk("ovr_valid", {31'b0, vld[0]}, 1);
        chk("ovr_flag", {31'b0, ovr[0]}, 1);
        accept(0);
        chk("ovr_valid_clr", {31'b0, vld[0]}, 0);
        chk("ovr_flag_clr", {31'b0, ovr[0]}, 0);
        send(0, {6'b0, 1'b1, 8'h33, 1'b0}, 10);
        chk("after_ovr_data", {24'b0, d0}, 32'h33);
        chk("after_ovr_flag", {31'b0, ovr[0]}, 0);

        // Reset mid-way through bit 4 with 0x33 still unconsumed
        send(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 5);
        rx_line[0] = 1'b1;
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", {31'b0, bsy[0]}, 1);
        start = 1'b0;
        #1;
        chk("mid_rst_data", {24'b0, d0}, 0);
        chk("mid_rst_valid", {31'b0, vld[0]}, 0);
        chk("mid_rst_busy", {31'b0, bsy[0]}, 0);
        chk("mid_rst_errs", {29'b0, ferr[0], perr[0], ovr[0]}, 0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_no_valid", {31'b0, vld[0]}, 0);
        send(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        chk("post_rst_data", {24'b0, d0}, 32'h5A);
        chk("post_rst_valid", {31'b0, vld[0]}, 1);
        chk("post_rst_ferr", {31'b0, ferr[0]}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
